// File: rtl/seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture
//
// Purpose:
//   Receive side of a multiplexed 4-digit 7-segment display bus. Watches the
//   segment lines and the active-low digit enables, waits for each digit's
//   pattern to settle, decodes the settled pattern back to BCD and publishes
//   one complete 4-digit frame per scan cycle.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical {SEG,AN} samples needed before a
//                  digit is captured (2..255)
//   CNT_W          width of the stability counter
//
// Ports:
//   CLK          system clock, rising edge
//   RESETN       asynchronous active-low reset
//   SEG[6:0]     segment lines, active-high, SEG[6]=a .. SEG[0]=g
//   AN[3:0]      digit enables, active-low, one-hot (AN[i]=0 selects digit i)
//   DIGITS[15:0] last complete frame, digit i in [4i+3:4i]
//   BLANK[3:0]   digit i was captured with all segments off
//   SEG_ERR[3:0] digit i was captured with an unrecognised pattern
//   FRAME_VALID  one-cycle pulse when DIGITS/BLANK/SEG_ERR update
// ---------------------------------------------------------------------------
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [6:0]  SEG,
    input  logic [3:0]  AN,
    output logic [15:0] DIGITS,
    output logic [3:0]  BLANK,
    output logic [3:0]  SEG_ERR,
    output logic        FRAME_VALID
);

    // Counter value at which a dwell is considered settled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [10:0]      w_newSample;
    logic [10:0]      r_prevSample;
    logic [CNT_W-1:0] r_stableCnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_captured;
    logic             w_sampleMatch;

    logic             w_anValid;
    logic [1:0]       w_digitIdx;
    logic [3:0]       w_digitOneHot;
    logic             w_capture;

    logic [3:0]       w_decNibble;
    logic             w_decBlank;
    logic             w_decErr;

    logic [15:0]      r_stageDigits;
    logic [3:0]       r_stageBlank;
    logic [3:0]       r_stageErr;
    logic [3:0]       r_mask;
    logic             w_frameDone;

    logic [15:0]      r_digits;
    logic [3:0]       r_blank;
    logic [3:0]       r_segErr;
    logic             r_frameValid;

    assign w_newSample   = {SEG, AN};
    assign w_sampleMatch = (w_newSample == r_prevSample);
    assign w_frameDone   = (r_mask == 4'hF);

    // Stability counter: restarts on any change between consecutive samples
    // and saturates once the dwell is settled, so long dwells never wrap
    // around into a second capture.
    always_comb begin
        w_cntNext = '0;
        if (w_sampleMatch) begin
            if (r_stableCnt == CNT_LAST) begin
                w_cntNext = r_stableCnt;
            end else begin
                w_cntNext = r_stableCnt + 1'b1;
            end
        end
    end

    // Enable qualification: exactly one low bit selects a digit. The
    // blanking interval (all high) and multi-low patterns select nothing.
    always_comb begin
        w_anValid     = 1'b0;
        w_digitIdx    = 2'd0;
        w_digitOneHot = 4'h0;
        case (AN)
            4'b1110: begin w_anValid = 1'b1; w_digitIdx = 2'd0; w_digitOneHot = 4'b0001; end
            4'b1101: begin w_anValid = 1'b1; w_digitIdx = 2'd1; w_digitOneHot = 4'b0010; end
            4'b1011: begin w_anValid = 1'b1; w_digitIdx = 2'd2; w_digitOneHot = 4'b0100; end
            4'b0111: begin w_anValid = 1'b1; w_digitIdx = 2'd3; w_digitOneHot = 4'b1000; end
            default: begin w_anValid = 1'b0; end
        endcase
    end

    // A capture fires on the single edge where the counter first reaches
    // its settled value; the captured flag blocks repeats for the rest of
    // the dwell.
    assign w_capture = w_anValid && (w_cntNext == CNT_LAST) && !r_captured;

    // Segment pattern back to BCD. The settled sample equals the live input
    // whenever a capture fires, so the registered copy is decoded to keep
    // the input path short.
    always_comb begin
        w_decNibble = 4'hE;
        w_decBlank  = 1'b0;
        w_decErr    = 1'b0;
        case (r_prevSample[10:4])
            7'h7E:   w_decNibble = 4'd0;
            7'h30:   w_decNibble = 4'd1;
            7'h6D:   w_decNibble = 4'd2;
            7'h79:   w_decNibble = 4'd3;
            7'h33:   w_decNibble = 4'd4;
            7'h5B:   w_decNibble = 4'd5;
            7'h5F:   w_decNibble = 4'd6;
            7'h70:   w_decNibble = 4'd7;
            7'h7F:   w_decNibble = 4'd8;
            7'h7B:   w_decNibble = 4'd9;
            7'h00: begin
                w_decNibble = 4'hF;
                w_decBlank  = 1'b1;
            end
            default: begin
                w_decNibble = 4'hE;
                w_decErr    = 1'b1;
            end
        endcase
    end

    // Input sample register, stability counter and once-per-dwell flag.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_prevSample <= '0;
            r_stableCnt  <= '0;
            r_captured   <= 1'b0;
        end else begin
            r_prevSample <= w_newSample;
            r_stableCnt  <= w_cntNext;
            if (!w_sampleMatch) begin
                r_captured <= 1'b0;
            end else if (w_capture) begin
                r_captured <= 1'b1;
            end
        end
    end

    // Staging entries: a capture always overwrites its digit, so a scan
    // restart or out-of-order scan simply refreshes the entry.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_stageDigits <= '0;
            r_stageBlank  <= '0;
            r_stageErr    <= '0;
        end else if (w_capture) begin
            r_stageDigits[{w_digitIdx, 2'b00} +: 4] <= w_decNibble;
            r_stageBlank[w_digitIdx]                <= w_decBlank;
            r_stageErr[w_digitIdx]                  <= w_decErr;
        end
    end

    // Capture mask: collects one bit per digit seen this frame. When the
    // frame is published the mask restarts, but a capture landing on that
    // same edge already belongs to the next frame and keeps its bit.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mask <= 4'h0;
        end else if (w_frameDone) begin
            r_mask <= w_capture ? w_digitOneHot : 4'h0;
        end else if (w_capture) begin
            r_mask <= r_mask | w_digitOneHot;
        end
    end

    // Published frame: staging (as it stood before this edge's capture) is
    // copied out one edge after the mask fills; outputs hold otherwise.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_digits     <= '0;
            r_blank      <= '0;
            r_segErr     <= '0;
            r_frameValid <= 1'b0;
        end else begin
            r_frameValid <= w_frameDone;
            if (w_frameDone) begin
                r_digits <= r_stageDigits;
                r_blank  <= r_stageBlank;
                r_segErr <= r_stageErr;
            end
        end
    end

    assign DIGITS      = r_digits;
    assign BLANK       = r_blank;
    assign SEG_ERR     = r_segErr;
    assign FRAME_VALID = r_frameValid;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_capture
//
// Drives directed scan sequences followed by randomized dwells into
// seg7_scan_capture. A behavioural model tracks run lengths of the sampled
// {SEG,AN} value, decodes via a pattern table and assembles frames; every
// cycle the DUT outputs are compared against it, and a few literal frame
// values pin the model itself.
// ---------------------------------------------------------------------------
module tb_seg7_scan_capture;

    localparam int S = 4;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic [15:0] DIGITS;
    logic [3:0]  BLANK;
    logic [3:0]  SEG_ERR;
    logic        FRAME_VALID;

    int checks  = 0;
    int errors  = 0;
    int fvSeen  = 0;
    logic checkEn = 1'b0;

    seg7_scan_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .CLK(CLK), .RESETN(RESETN), .SEG(SEG), .AN(AN),
        .DIGITS(DIGITS), .BLANK(BLANK), .SEG_ERR(SEG_ERR),
        .FRAME_VALID(FRAME_VALID)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    // Reference segment patterns for digits 0..9.
    logic [6:0] patTable [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // Table lookup decode: digit index, blank, or error.
    function automatic void decodeModel(input logic [6:0] seg,
                                        output logic [3:0] nib,
                                        output logic bl, output logic er);
        nib = 4'hE; bl = 1'b0; er = 1'b1;
        if (seg == 7'h00) begin
            nib = 4'hF; bl = 1'b1; er = 1'b0;
        end else begin
            for (int k = 0; k < 10; k++) begin
                if (patTable[k] == seg) begin
                    nib = 4'(k); er = 1'b0;
                end
            end
        end
    endfunction

    // Model state: the last sampled value, how many consecutive edges it has
    // been seen, per-digit staging, the set of digits collected this frame,
    // and the outputs the DUT must show.
    logic [10:0] mLast;
    int          mRun;
    logic [3:0]  mStage [4];
    logic [3:0]  mStageB, mStageE, mMask;
    logic        mPending;
    logic [15:0] expDigits;
    logic [3:0]  expBlank, expErr;
    logic        expFv;

    // Model step per clock edge; reset clears everything immediately.
    always @(posedge CLK or negedge RESETN) begin
        logic [10:0] cur;
        logic [3:0]  nib;
        logic        bl, er;
        int          idx;
        if (!RESETN) begin
            mLast = '0; mRun = 1;
            for (int k = 0; k < 4; k++) mStage[k] = 4'h0;
            mStageB = 0; mStageE = 0; mMask = 0; mPending = 0;
            expDigits = 0; expBlank = 0; expErr = 0; expFv = 0;
        end else begin
            cur = {SEG, AN};
            if (cur == mLast) mRun = mRun + 1;
            else mRun = 1;
            mLast = cur;
            expFv = 1'b0;
            if (mPending) begin
                expDigits = {mStage[3], mStage[2], mStage[1], mStage[0]};
                expBlank  = mStageB;
                expErr    = mStageE;
                expFv     = 1'b1;
                mMask     = 4'h0;
            end
            if (mRun == S && $countones(cur[3:0]) == 3) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (cur[k] == 1'b0) idx = k;
                decodeModel(cur[10:4], nib, bl, er);
                mStage[idx]  = nib;
                mStageB[idx] = bl;
                mStageE[idx] = er;
                mMask[idx]   = 1'b1;
            end
            mPending = (mMask == 4'hF);
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of every output against the model, 1 unit after
    // the rising edge.
    always @(posedge CLK) begin
        #1;
        if (checkEn) begin
            checkOutput("digits", DIGITS, expDigits);
            checkOutput("blank", {12'h0, BLANK}, {12'h0, expBlank});
            checkOutput("seg_err", {12'h0, SEG_ERR}, {12'h0, expErr});
            checkOutput("frame_valid", {15'h0, FRAME_VALID}, {15'h0, expFv});
            if (FRAME_VALID === 1'b1) fvSeen++;
        end
    end

    // Hold one {SEG,AN} value for a number of cycles (driven at negedge).
    task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] an,
                                 input int cycles);
        SEG = seg;
        AN  = an;
        repeat (cycles) @(negedge CLK);
    endtask

    int base;
    logic [3:0] anSel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        RESETN = 1'b0;
        SEG = 7'h00;
        AN  = 4'hF;
        @(negedge CLK);
        checkEn = 1'b1;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        checkOutput("reset_digits", DIGITS, 16'h0000);
        checkOutput("reset_fv", {15'h0, FRAME_VALID}, 16'h0000);

        // Basic scan 0,1,2,3.
        base = fvSeen;
        applyStimulus(7'h7E, 4'b1110, 8);
        applyStimulus(7'h30, 4'b1101, 8);
        applyStimulus(7'h6D, 4'b1011, 8);
        applyStimulus(7'h79, 4'b0111, 8);
        applyStimulus(7'h00, 4'hF, 4);
        checkOutput("t1_digits", DIGITS, 16'h3210);
        checkOutput("t1_blank_err", {8'h0, BLANK, SEG_ERR}, 16'h0000);
        checkOutput("t1_frames", 16'(fvSeen - base), 16'd1);

        // Same scan with a short 8-pattern glitch before every digit.
        base = fvSeen;
        applyStimulus(7'h7F, 4'b1110, 2); applyStimulus(7'h7E, 4'b1110, 6);
        applyStimulus(7'h7F, 4'b1101, 2); applyStimulus(7'h30, 4'b1101, 6);
        applyStimulus(7'h7F, 4'b1011, 2); applyStimulus(7'h6D, 4'b1011, 6);
        applyStimulus(7'h7F, 4'b0111, 2); applyStimulus(7'h79, 4'b0111, 6);
        applyStimulus(7'h00, 4'hF, 4);
        checkOutput("t2_digits", DIGITS, 16'h3210);
        checkOutput("t2_frames", 16'(fvSeen - base), 16'd1);

        // Blank digit 2 and illegal pattern on digit 1.
        base = fvSeen;
        applyStimulus(7'h7E, 4'b1110, 8);
        applyStimulus(7'h01, 4'b1101, 8);
        applyStimulus(7'h00, 4'b1011, 8);
        applyStimulus(7'h79, 4'b0111, 8);
        applyStimulus(7'h00, 4'hF, 4);
        checkOutput("t3_digits", DIGITS, 16'h3FE0);
        checkOutput("t3_blank", {12'h0, BLANK}, 16'h0004);
        checkOutput("t3_err", {12'h0, SEG_ERR}, 16'h0002);
        checkOutput("t3_frames", 16'(fvSeen - base), 16'd1);

        // Blanking gaps and a multi-low enable dwell never capture.
        base = fvSeen;
        applyStimulus(7'h5B, 4'b1110, 8);
        applyStimulus(7'h00, 4'hF, 5);
        applyStimulus(7'h7E, 4'b1100, 10);
        applyStimulus(7'h5F, 4'b1101, 8);
        applyStimulus(7'h00, 4'hF, 5);
        applyStimulus(7'h70, 4'b1011, 8);
        applyStimulus(7'h00, 4'hF, 5);
        checkOutput("t4_no_early_frame", 16'(fvSeen - base), 16'd0);
        applyStimulus(7'h7B, 4'b0111, 8);
        applyStimulus(7'h00, 4'hF, 4);
        checkOutput("t4_digits", DIGITS, 16'h9765);
        checkOutput("t4_frames", 16'(fvSeen - base), 16'd1);

        // Long dwell on digit 0 captures once.
        base = fvSeen;
        applyStimulus(7'h33, 4'b1110, 40);
        applyStimulus(7'h30, 4'b1101, 8);
        applyStimulus(7'h7F, 4'b1011, 8);
        applyStimulus(7'h6D, 4'b0111, 8);
        applyStimulus(7'h00, 4'hF, 4);
        checkOutput("t5_digits", DIGITS, 16'h2814);
        checkOutput("t5_frames", 16'(fvSeen - base), 16'd1);

        // Reset mid-frame discards the partial frame.
        applyStimulus(7'h7E, 4'b1110, 8);
        applyStimulus(7'h30, 4'b1101, 8);
        SEG = 7'h00; AN = 4'hF;
        RESETN = 1'b0;
        #1;
        checkOutput("t6_rst_digits", DIGITS, 16'h0000);
        checkOutput("t6_rst_flags", {7'h0, FRAME_VALID, BLANK, SEG_ERR}, 16'h0000);
        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        base = fvSeen;
        applyStimulus(7'h00, 4'hF, 6);
        checkOutput("t6_no_partial_frame", 16'(fvSeen - base), 16'd0);
        applyStimulus(7'h5B, 4'b1110, 8);
        applyStimulus(7'h5F, 4'b1101, 8);
        applyStimulus(7'h70, 4'b1011, 8);
        applyStimulus(7'h7F, 4'b0111, 8);
        applyStimulus(7'h00, 4'hF, 4);
        checkOutput("t6_digits", DIGITS, 16'h8765);
        checkOutput("t6_frames", 16'(fvSeen - base), 16'd1);

        // Randomized dwells, checked cycle by cycle against the model.
        for (int n = 0; n < 400; n++) begin
            logic [6:0] s;
            logic [3:0] a;
            int sel;
            sel = $urandom_range(0, 13);
            if (sel < 10) s = patTable[sel];
            else if (sel == 10) s = 7'h00;
            else if (sel == 11) s = 7'($urandom);
            else s = patTable[$urandom_range(0, 9)];
            sel = $urandom_range(0, 5);
            if (sel < 4) a = anSel[sel];
            else if (sel == 4) a = 4'hF;
            else a = 4'($urandom);
            applyStimulus(s, a, $urandom_range(1, 9));
        end
        applyStimulus(7'h00, 4'hF, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
